// File: rtl/seq_adder.sv
// seq_adder: multi-cycle adder/subtractor, DIGIT bits per clock, LSB first.
// Valid/ready handshakes on the request and result sides; reports carry-out
// and two's-complement overflow.
// Optional accumulate mode: define SEQ_ADDER_ACC_EN to build the accumulator.
// With that macro undefined, the acc input is ignored and A always comes from a.
module seq_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_sub,
   input  logic             i_acc,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int unsigned N    = WIDTH / DIGIT;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] LastDigit = CntW'(N - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                 r_state, w_state_d;
   logic [WIDTH-1:0]       r_a, w_a_d;
   logic [WIDTH-1:0]       r_b, w_b_d;
   logic [WIDTH-1:0]       r_res, w_res_d;
   logic                   r_carry, w_carry_d;
   logic                   r_cout, w_cout_d;
   logic                   r_ovf, w_ovf_d;
   logic [CntW-1:0]        r_cnt, w_cnt_d;

   logic [DIGIT:0]         w_dsum;
   logic [WIDTH+DIGIT-1:0] w_shift;
   logic                   w_msb_cin;
   logic                   w_accept;
   logic                   w_last;
   logic [WIDTH-1:0]       w_a_src;

   // Per-digit adder: low DIGIT bits of each operand plus the running carry.
   assign w_dsum  = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, r_carry};
   // New digit enters at the MSB end; the slice drops the oldest DIGIT bits.
   assign w_shift = {w_dsum[DIGIT-1:0], r_res};
   // Carry into the top bit recovered from its sum bit: s = a ^ b ^ c.
   assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];
   assign w_last    = (r_state == StRun) && (r_cnt == LastDigit);
   assign w_accept  = i_in_valid && o_in_ready;

`ifdef SEQ_ADDER_ACC_EN
   logic [WIDTH-1:0] r_acc;

   // Accumulator takes the final sum on the edge that enters DONE.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc <= '0;
      end else if (w_last) begin
         r_acc <= w_shift[WIDTH+DIGIT-1:DIGIT];
      end
   end

   assign w_a_src = i_acc ? r_acc : i_a;
`else
   logic w_unused_acc;
   assign w_unused_acc = i_acc;
   assign w_a_src      = i_a;
`endif

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_a     <= w_a_d;
         r_b     <= w_b_d;
         r_res   <= w_res_d;
         r_carry <= w_carry_d;
         r_cout  <= w_cout_d;
         r_ovf   <= w_ovf_d;
         r_cnt   <= w_cnt_d;
      end
   end

   // Next-state, datapath next values and handshake outputs.
   always_comb begin
      w_state_d   = r_state;
      w_a_d       = r_a;
      w_b_d       = r_b;
      w_res_d     = r_res;
      w_carry_d   = r_carry;
      w_cout_d    = r_cout;
      w_ovf_d     = r_ovf;
      w_cnt_d     = r_cnt;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;

      unique case (r_state)
         StIdle: begin
            // Reset is synchronous, but ready is masked so nothing looks accepted.
            o_in_ready = !i_rst;
            if (w_accept) begin
               w_a_d     = w_a_src;
               w_b_d     = i_sub ? ~i_b : i_b;
               w_carry_d = i_sub ? 1'b1 : i_cin;
               w_cnt_d   = '0;
               w_state_d = StRun;
            end
         end
         StRun: begin
            w_a_d     = r_a >> DIGIT;
            w_b_d     = r_b >> DIGIT;
            w_res_d   = w_shift[WIDTH+DIGIT-1:DIGIT];
            w_carry_d = w_dsum[DIGIT];
            w_cnt_d   = r_cnt + 1'b1;
            if (w_last) begin
               w_cout_d  = w_dsum[DIGIT];
               w_ovf_d   = w_msb_cin ^ w_dsum[DIGIT];
               w_cnt_d   = '0;
               w_state_d = StDone;
            end
         end
         StDone: begin
            o_out_valid = 1'b1;
            if (i_out_ready) begin
               w_state_d = StIdle;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   assign o_sum  = r_res;
   assign o_cout = r_cout;
   assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: directed self-checking bench for seq_adder (WIDTH=8, DIGIT=2).
// Expected results follow SEQ_ADDER_ACC_EN when the accumulate section runs.
module tb_seq_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       sub;
   logic       acc;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;

   int n_checks = 0;
   int n_fail   = 0;

   seq_adder #(
      .WIDTH (8),
      .DIGIT (2)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_a         (a),
      .i_b         (b),
      .i_cin       (cin),
      .i_sub       (sub),
      .i_acc       (acc),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_sum       (sum),
      .o_cout      (cout),
      .o_ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for out_valid; returns the number of edges waited.
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   task automatic do_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic icin, input logic isub, input logic iacc,
                        input logic [7:0] es, input logic ec, input logic eo);
      int cyc;
      a = ia; b = ib; cin = icin; sub = isub; acc = iacc;
      in_valid = 1'b1;
      check({tag, " in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      check({tag, " busy"}, in_ready, 0);
      wait_valid(cyc);
      check({tag, " latency"}, cyc, 4);
      check({tag, " sum"}, sum, es);
      check({tag, " cout"}, cout, ec);
      check({tag, " ovf"}, ovf, eo);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " valid drop"}, out_valid, 0);
      check({tag, " ready back"}, in_ready, 1);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      int cyc;
      rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
      cin = 1'b1; sub = 1'b0; acc = 1'b0; out_ready = 1'b0;

      // Reset with in_valid high: reset wins.
      tick();
      tick();
      check("rst in_ready", in_ready, 0);
      check("rst out_valid", out_valid, 0);
      check("rst sum", sum, 8'h00);
      check("rst cout", cout, 0);
      check("rst ovf", ovf, 0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("post-rst in_ready", in_ready, 1);
      tick();
      check("post-rst no valid", out_valid, 0);

      do_op("add ovf", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
      do_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      do_op("cin", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
      do_op("sub borrow", 8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
      do_op("sub ovf", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

      // Backpressure: result held, requests refused while out_ready is low.
      a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; acc = 1'b0;
      in_valid = 1'b1;
      tick();
      wait_valid(cyc);
      check("bp latency", cyc, 4);
      for (int i = 0; i < 10; i++) begin
         a = 8'(i * 17 + 3);
         b = ~a;
         check("bp sum held", sum, 8'h96);
         check("bp in_ready low", in_ready, 0);
         check("bp valid held", out_valid, 1);
         tick();
      end
      a = 8'h01; b = 8'h02;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp release valid", out_valid, 0);
      check("bp release ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("bp one accepted", in_ready, 0);
      wait_valid(cyc);
      check("bp next latency", cyc, 4);
      check("bp next sum", sum, 8'h03);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp no extra valid", out_valid, 0);
         check("bp idle ready", in_ready, 1);
         tick();
      end

      // Accumulate from a fresh reset.
      pulse_reset();
`ifdef SEQ_ADDER_ACC_EN
      do_op("acc 1", 8'h01, 8'h40, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
      do_op("acc 2", 8'h01, 8'h40, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
      do_op("acc 3", 8'h01, 8'h40, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b0);
`else
      do_op("acc 1", 8'h01, 8'h40, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
      do_op("acc 2", 8'h01, 8'h40, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
      do_op("acc 3", 8'h01, 8'h40, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
`endif

      // Reset asserted so that it is sampled at E2 of a running operation.
      a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; acc = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("midrst in_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      check("midrst ready after", in_ready, 1);
      check("midrst sum cleared", sum, 8'h00);
      check("midrst cout cleared", cout, 0);
      check("midrst ovf cleared", ovf, 0);
      for (int i = 0; i < 6; i++) begin
         check("midrst no valid", out_valid, 0);
         tick();
      end
`ifdef SEQ_ADDER_ACC_EN
      do_op("midrst acc zero", 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
`else
      do_op("midrst acc ignored", 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
`endif
      do_op("midrst next add", 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_adder.md
# seq_adder

Parametrised multi-cycle adder/subtractor with valid/ready handshakes on both sides. It processes operands DIGIT bits per clock, LSB first, and reports carry-out and signed overflow. An optional accumulate mode adds each operand to the running result. It is the parametrised, sequential successor to the team's 4-bit combinational adder and sits between the tile's `ui_in`/`uio_in` unpacking logic and `uo_out`.

## Interface
- `WIDTH`, 8: operand and result width in bits; must be a multiple of DIGIT and at least 2.
- `DIGIT`, 2: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operand request valid.
- `in_ready` output 1: block can accept a request.
- `a` input WIDTH: operand A; ignored when `acc` is 1 and accumulate is compiled in.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in; ignored when `sub` is 1.
- `sub` input 1: 0 computes A+B+cin; 1 computes A−B, i.e. A+~B+1.
- `acc` input 1: 1 uses the internal accumulator register as A.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `sum` output WIDTH: result.
- `cout` output 1: carry out of the MSB. For subtraction, 1 means no borrow.
- `ovf` output 1: two's-complement overflow, equal to carry-into-MSB XOR carry-out-of-MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - Latch A, or the accumulator if `acc`.
    - Latch B, or ~B if `sub`.
    - Set the carry register to `sub` ? 1 : `cin`.
    - Clear the digit counter and go to RUN.
- RUN
  - `in_ready`=0.
  - Each cycle, add the low DIGIT bits of the A and B shift registers plus the carry.
  - Shift the DIGIT-bit result into the MSB end of the result register, shift the operands right by DIGIT, and update the carry.
  - On the last digit, capture the carry into the MSB as the `ovf` source.
  - After N=WIDTH/DIGIT digits, go to DONE.
- DONE
  - `out_valid`=1; `sum`/`cout`/`ovf` are stable.
  - The accumulator register is loaded with `sum` on entry to DONE.
  - On `out_ready`, go to IDLE.
- No request is accepted in RUN or DONE. Inputs presented then are ignored and no data is lost, because `in_ready`=0.
- Arithmetic is modulo 2^WIDTH; `sum` wraps.
- Reset values:
  - `in_ready` reads 0 while `rst`=1 and 1 afterwards.
  - `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
  - Accumulator = 0.
  - Digit counter = 0.

## Timing
- Accept edge = E0. Digits are processed on edges E1..EN.
- `out_valid` rises in the cycle after EN, i.e. N cycles after acceptance. With WIDTH=8 and DIGIT=2, that is 4 cycles.
- The result is held indefinitely while `out_ready`=0.
- `out_valid` falls on the edge where `out_valid`&&`out_ready`. `in_ready` rises in that same cycle.
- Minimum request-to-request spacing is N+2 cycles.
- `rst` asserted in any state, including mid-RUN, aborts the operation at the next edge:
  - no `out_valid` pulse;
  - partial result discarded;
  - accumulator cleared.
- `in_valid` and `rst` high together: reset wins and nothing is latched.

## Configuration
- `SEQ_ADDER_ACC_EN` defined:
  - The accumulator register and `acc` input behaviour are present.
  - `acc`=1 substitutes the accumulator for `a`.
- Not defined:
  - No accumulator register is synthesised.
  - The `acc` port remains but is ignored; A always comes from `a`.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8, DIGIT=2.
- Add with signed overflow: a=0x5A, b=0x3C, sub=0, cin=0 → sum=0x96, cout=0, ovf=1; `out_valid` exactly 4 cycles after accept.
- Unsigned wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 → sum=0x01.
- Subtract with borrow: a=0x10, b=0x20, sub=1, cin=1 (must be ignored) → sum=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`, with `in_valid`=1 and changing a/b throughout → sum stays 0x96, `in_ready`=0 throughout. After `out_ready`, exactly one new request is accepted.
- Accumulate (macro defined): from reset, three requests with acc=1, b=0x40 → results 0x40 (ovf=0), 0x80 (ovf=1), 0xC0 (ovf=0). With the macro undefined and a=0x01 → every result is 0x41.
- Reset mid-RUN: assert `rst` for 1 cycle at E2 → no `out_valid`, `in_ready`=1 one cycle after reset deasserts, accumulator=0. The next add 0x01+0x02 → 0x03.
